// File: rtl/defuzzificador_sequencial.sv
// Sequential centroid defuzzifier: max-aggregates rule strengths per output
// set, then computes the weighted average of the set centres with a
// bit-serial restoring divider.
module defuzzificador_sequencial #(
  parameter logic [7:0] CENTRO_BAIXO = 8'd32,
  parameter logic [7:0] CENTRO_MEDIO = 8'd128,
  parameter logic [7:0] CENTRO_ALTO  = 8'd224,
  parameter logic [7:0] SAIDA_PADRAO = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] codigo,
  input  logic [7:0] grau,
  input  logic       valido,
  input  logic       ultimo,
  output logic [7:0] saida,
  output logic       pronto,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [1:0] {ACUMULA, SOMA, DIVIDE, SAIDA} estado_t;

  estado_t     state_q, state_d;
  logic [7:0]  agg_b_q, agg_b_d;
  logic [7:0]  agg_m_q, agg_m_d;
  logic [7:0]  agg_a_q, agg_a_d;
  logic        erro_pend_q, erro_pend_d;
  logic [9:0]  rem_q, rem_d;
  logic [7:0]  num_lo_q, num_lo_d;
  logic [7:0]  quo_q, quo_d;
  logic [9:0]  den_q, den_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  saida_q, saida_d;
  logic        pronto_q, pronto_d;
  logic        ocupado_q, ocupado_d;
  logic        erro_q, erro_d;

  // Weighted sum and total strength of the aggregated sets (max 97920, fits 18 bits)
  logic [17:0] num_c;
  logic [9:0]  den_c;
  assign num_c = ({10'd0, agg_b_q} * {10'd0, CENTRO_BAIXO})
               + ({10'd0, agg_m_q} * {10'd0, CENTRO_MEDIO})
               + ({10'd0, agg_a_q} * {10'd0, CENTRO_ALTO});
  assign den_c = {2'b00, agg_b_q} + {2'b00, agg_m_q} + {2'b00, agg_a_q};

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  // The partial remainder is always below den, so the low 10 bits of the
  // difference are exact whenever the subtraction is taken.
  logic [10:0] trial_c;
  logic [9:0]  diff_c;
  logic        ge_c;
  assign trial_c = {rem_q, num_lo_q[7]};
  assign diff_c  = trial_c[9:0] - den_q;
  assign ge_c    = (trial_c >= {1'b0, den_q});

  // Next-state and next-output computation for the whole sweep sequence
  always_comb begin
    state_d     = state_q;
    agg_b_d     = agg_b_q;
    agg_m_d     = agg_m_q;
    agg_a_d     = agg_a_q;
    erro_pend_d = erro_pend_q;
    rem_d       = rem_q;
    num_lo_d    = num_lo_q;
    quo_d       = quo_q;
    den_d       = den_q;
    cnt_d       = cnt_q;
    saida_d     = saida_q;
    pronto_d    = 1'b0;
    ocupado_d   = ocupado_q;
    erro_d      = erro_q;
    case (state_q)
      ACUMULA: begin
        ocupado_d = 1'b0;
        if (valido) begin
          case (codigo)
            3'b001:  if (grau > agg_b_q) agg_b_d = grau;
            3'b010:  if (grau > agg_m_q) agg_m_d = grau;
            3'b100:  if (grau > agg_a_q) agg_a_d = grau;
            default: erro_pend_d = 1'b1;
          endcase
          if (ultimo) begin
            state_d   = SOMA;
            ocupado_d = 1'b1;
          end
        end
      end
      SOMA: begin
        // Quotient fits 8 bits, so the top 10 dividend bits are already below den
        rem_d    = num_c[17:8];
        num_lo_d = num_c[7:0];
        den_d    = den_c;
        quo_d    = 8'd0;
        cnt_d    = 3'd0;
        state_d  = DIVIDE;
      end
      DIVIDE: begin
        rem_d    = ge_c ? diff_c : trial_c[9:0];
        quo_d    = {quo_q[6:0], ge_c};
        num_lo_d = {num_lo_q[6:0], 1'b0};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = SAIDA;
      end
      SAIDA: begin
        saida_d     = (den_q == 10'd0) ? SAIDA_PADRAO : quo_q;
        pronto_d    = 1'b1;
        erro_d      = erro_pend_q | (den_q == 10'd0);
        agg_b_d     = 8'd0;
        agg_m_d     = 8'd0;
        agg_a_d     = 8'd0;
        erro_pend_d = 1'b0;
        ocupado_d   = 1'b0;
        state_d     = ACUMULA;
      end
      default: state_d = ACUMULA;
    endcase
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACUMULA;
      agg_b_q     <= 8'd0;
      agg_m_q     <= 8'd0;
      agg_a_q     <= 8'd0;
      erro_pend_q <= 1'b0;
      rem_q       <= 10'd0;
      num_lo_q    <= 8'd0;
      quo_q       <= 8'd0;
      den_q       <= 10'd0;
      cnt_q       <= 3'd0;
      saida_q     <= 8'd0;
      pronto_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      agg_b_q     <= agg_b_d;
      agg_m_q     <= agg_m_d;
      agg_a_q     <= agg_a_d;
      erro_pend_q <= erro_pend_d;
      rem_q       <= rem_d;
      num_lo_q    <= num_lo_d;
      quo_q       <= quo_d;
      den_q       <= den_d;
      cnt_q       <= cnt_d;
      saida_q     <= saida_d;
      pronto_q    <= pronto_d;
      ocupado_q   <= ocupado_d;
      erro_q      <= erro_d;
    end
  end

  assign saida   = saida_q;
  assign pronto  = pronto_q;
  assign ocupado = ocupado_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_defuzzificador_sequencial.sv
// Self-checking bench for the sequential defuzzifier: directed sweeps,
// mid-computation reset and randomized sweeps against a centroid model.
module tb_defuzzificador_sequencial;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] codigo;
  logic [7:0] grau;
  logic       valido;
  logic       ultimo;
  logic [7:0] saida;
  logic       pronto;
  logic       ocupado;
  logic       erro;

  defuzzificador_sequencial dut (
    .clk(clk), .rst(rst), .codigo(codigo), .grau(grau), .valido(valido),
    .ultimo(ultimo), .saida(saida), .pronto(pronto), .ocupado(ocupado), .erro(erro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: strongest firing per output set, invalid-code flag
  int m_b, m_m, m_a;
  bit m_err;
  int last_saida, last_erro;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_b = 0; m_m = 0; m_a = 0; m_err = 0;
  endtask

  task automatic rule(input logic [2:0] c, input int g, input bit u);
    @(negedge clk);
    codigo = c; grau = g[7:0]; valido = 1'b1; ultimo = u;
    if (c == 3'b001)      m_b = (g > m_b) ? g : m_b;
    else if (c == 3'b010) m_m = (g > m_m) ? g : m_m;
    else if (c == 3'b100) m_a = (g > m_a) ? g : m_a;
    else                  m_err = 1;
    @(posedge clk); #1;
    valido = 1'b0; ultimo = 1'b0;
  endtask

  // Called #1 after the edge that sampled the ultimo rule
  task automatic finish_sweep(input string tag, input bit noise);
    int den, exp_s, exp_e, n;
    den   = m_b + m_m + m_a;
    exp_s = (den == 0) ? 128 : (m_b * 32 + m_m * 128 + m_a * 224) / den;
    exp_e = (m_err || den == 0) ? 1 : 0;
    chk({tag, "_ocupado"}, ocupado, 1);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (pronto) break;
      if (noise) begin
        valido = 1'($urandom); ultimo = 1'($urandom);
        codigo = 3'($urandom); grau = 8'($urandom);
      end
    end
    valido = 1'b0; ultimo = 1'b0;
    chk({tag, "_latency"}, n, 10);
    chk({tag, "_saida"}, saida, exp_s);
    chk({tag, "_erro"}, erro, exp_e);
    $display("sweep %s: b=%0d m=%0d a=%0d saida=%0d erro=%0d latency=%0d",
             tag, m_b, m_m, m_a, saida, erro, n);
    last_saida = exp_s; last_erro = exp_e;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, pronto, 0);
    chk({tag, "_hold"}, saida, last_saida);
    model_clear();
  endtask

  initial begin
    int nrules, n;
    bit seen;
    rst = 1'b0; codigo = 3'b000; grau = 8'd0; valido = 1'b0; ultimo = 1'b0;
    model_clear();
    #12;
    chk("rst_saida", saida, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro, 0);
    @(negedge clk); rst = 1'b1;

    rule(3'b010, 200, 1); finish_sweep("single_m200", 0);
    rule(3'b001, 60, 0); rule(3'b010, 120, 0); rule(3'b010, 200, 1);
    finish_sweep("mix105", 0);
    rule(3'b001, 100, 0); rule(3'b100, 100, 1); finish_sweep("b_a_128", 0);
    rule(3'b001, 255, 1); finish_sweep("b255", 0);
    rule(3'b100, 0, 1); finish_sweep("den_zero", 0);
    rule(3'b011, 90, 0); rule(3'b100, 50, 1); finish_sweep("invalid", 1);
    // erro must clear again after a clean sweep
    rule(3'b001, 10, 0); rule(3'b010, 30, 1); finish_sweep("clean", 1);

    // Reset while dividing: no pronto, outputs cleared, fresh aggregators after
    rule(3'b100, 250, 0); rule(3'b001, 40, 1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_saida", saida, 0);
    chk("midrst_pronto", pronto, 0);
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_erro", erro, 0);
    @(negedge clk); rst = 1'b1;
    model_clear();
    seen = 0;
    for (n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (pronto) seen = 1;
    end
    chk("midrst_no_pronto", seen, 0);
    rule(3'b010, 10, 1); finish_sweep("after_rst", 0);

    // Randomized sweeps including invalid codes and zero strengths
    for (int s = 0; s < 25; s++) begin
      nrules = $urandom_range(0, 5);
      for (int r = 0; r < nrules; r++) begin
        case ($urandom_range(0, 3))
          0: rule(3'b001, $urandom_range(0, 255), 0);
          1: rule(3'b010, $urandom_range(0, 255), 0);
          2: rule(3'b100, $urandom_range(0, 255), 0);
          default: rule(3'($urandom_range(0, 7)), $urandom_range(0, 255), 0);
        endcase
        if ($urandom_range(0, 2) == 0) begin
          @(negedge clk); ultimo = 1'b1; // ultimo without valido is ignored
          @(posedge clk); #1; ultimo = 1'b0;
        end
      end
      rule(($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'(1 << $urandom_range(0, 2)),
           ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(0, 255), 1);
      finish_sweep($sformatf("rand%0d", s), s[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
